// File: rtl/ftdi_fifo_writer.sv
// FT232H async-245 transmit path: byte buffer plus WR# strobe sequencer sharing ADBUS with the read path.
// Define FTDI_SIWU_EN to add the Send-Immediate flush pulse on SIWU#; otherwise siwu_n is tied high.
module ftdi_fifo_writer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned WR_LOW_CYC  = 3,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     txe_n,
    input  logic                     bus_grant,
    output logic                     bus_busy,
    output logic                     ftdi_wr,
    output logic [7:0]               adbus_out,
    output logic                     adbus_tri,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     siwu_n
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned MAX_A = (SETUP_CYC > WR_LOW_CYC) ? SETUP_CYC : WR_LOW_CYC;
    localparam int unsigned MAX_B = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int unsigned TMAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          txe_meta, txe_s;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_d;
    logic          push, pop, drive_d;

    // TXE# is asynchronous to clock; every decision uses the synchronized copy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            txe_meta <= txe_n;
            txe_s    <= txe_meta;
        end
    end

    assign push = wr_valid && wr_ready;

    always_comb begin
        count_d = fifo_count;
        case ({push, pop})
            2'b10:   count_d = fifo_count + CW'(1);
            2'b01:   count_d = fifo_count - CW'(1);
            default: count_d = fifo_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            wr_ready   <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= count_d;
            wr_ready   <= (count_d < CW'(DEPTH));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Each timed state reloads its counter on entry and leaves when it reaches zero.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (fifo_count != '0) && !txe_s && bus_grant) begin
                    state_d = SETUP;
                    tmr_d   = TW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (txe_s || !bus_grant) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    state_d = STROBE;
                    tmr_d   = TW'(WR_LOW_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            STROBE: begin
                if (tmr_q == '0) begin
                    state_d = HOLD;
                    tmr_d   = TW'(HOLD_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            HOLD: begin
                if (tmr_q == '0) begin
                    state_d = RECOVER;
                    tmr_d   = TW'(RECOVER_CYC - 1);
                    pop     = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RECOVER: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        drive_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    end

    // Pad controls track the next state so they line up with it after the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ftdi_wr   <= 1'b1;
            adbus_tri <= 1'b0;
            bus_busy  <= 1'b0;
            adbus_out <= '0;
        end else begin
            ftdi_wr   <= (state_d != STROBE);
            adbus_tri <= drive_d;
            bus_busy  <= drive_d;
            if ((state_q == IDLE) && (state_d == SETUP)) adbus_out <= mem[rd_ptr];
        end
    end

`ifdef FTDI_SIWU_EN
    localparam int unsigned FLUSH_IDLE = 64;

    logic [6:0]    idle_q;
    logic          pending_q;
    logic [TW-1:0] siwu_tmr_q, siwu_tmr_d;
    logic          idle_ok, fire;

    // Flush once the buffer has sat empty in IDLE long enough after at least one byte went out.
    always_comb begin
        idle_ok    = (state_q == IDLE) && (fifo_count == '0) && !push;
        fire       = idle_ok && pending_q && (idle_q == 7'(FLUSH_IDLE - 1)) && (siwu_tmr_q == '0);
        siwu_tmr_d = siwu_tmr_q;
        if (fire) begin
            siwu_tmr_d = TW'(WR_LOW_CYC);
        end else if (siwu_tmr_q != '0) begin
            siwu_tmr_d = siwu_tmr_q - TW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_q     <= '0;
            pending_q  <= 1'b0;
            siwu_tmr_q <= '0;
            siwu_n     <= 1'b1;
        end else begin
            siwu_tmr_q <= siwu_tmr_d;
            siwu_n     <= !((siwu_tmr_d != '0) && !drive_d);
            if (!idle_ok) begin
                idle_q <= '0;
            end else if (idle_q != 7'(FLUSH_IDLE - 1)) begin
                idle_q <= idle_q + 7'd1;
            end
            if (pop) begin
                pending_q <= 1'b1;
            end else if (fire) begin
                pending_q <= 1'b0;
            end
        end
    end
`else
    assign siwu_n = 1'b1;
`endif

endmodule
